// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions for the instruction encoder and the control decoder:
// operation enum, 6-bit opcode values, field positions and legality helpers.
package proc_isa_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_LW  = 3'd4,
    OP_SW  = 3'd5
  } op_e;

  localparam logic [5:0] OPC_ADD = 6'd1;
  localparam logic [5:0] OPC_LW  = 6'd2;
  localparam logic [5:0] OPC_SUB = 6'd3;
  localparam logic [5:0] OPC_SW  = 6'd4;
  localparam logic [5:0] OPC_AND = 6'd5;
  localparam logic [5:0] OPC_OR  = 6'd6;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  function automatic logic is_legal(input logic [2:0] op);
    return op <= 3'(OP_SW);
  endfunction

  function automatic logic is_rtype(input logic [2:0] op);
    return op <= 3'(OP_OR);
  endfunction

  // Illegal codes map to 0 so a stray encode never yields a valid opcode.
  function automatic logic [5:0] opcode_of(input logic [2:0] op);
    logic [5:0] opc;
    opc = 6'd0;
    case (op)
      3'(OP_ADD): opc = OPC_ADD;
      3'(OP_SUB): opc = OPC_SUB;
      3'(OP_AND): opc = OPC_AND;
      3'(OP_OR):  opc = OPC_OR;
      3'(OP_LW):  opc = OPC_LW;
      3'(OP_SW):  opc = OPC_SW;
      default:    opc = 6'd0;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; occupancy is tracked in an
// explicit level counter so the pointers can wrap freely.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_wr, do_rd;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level gates every read of it.
  always_ff @(posedge clk) begin
    if (do_wr && !reset) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic operation requests into 32-bit instruction words, buffers
// them in a FWFT FIFO and counts words handed to instruction memory.
module instr_encoder
  import proc_isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [4:0]                 in_rs,
  input  logic [4:0]                 in_rt,
  input  logic [4:0]                 in_rd,
  input  logic [15:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic                       err_illegal,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           issued_count
);

  localparam int LVL_W = $clog2(DEPTH+1);

  logic [31:0]      word;
  logic             accept, push, pop;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    word = '0;
    word[OPC_MSB:OPC_LSB] = opcode_of(in_op);
    word[RS_MSB:RS_LSB]   = in_rs;
    word[RT_MSB:RT_LSB]   = in_rt;
    if (is_rtype(in_op)) word[RD_MSB:RD_LSB]   = in_rd;
    else                 word[IMM_MSB:IMM_LSB] = in_imm;
  end

  // Illegal ops still handshake so the loader never stalls on them.
  assign in_ready  = !reset && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && is_legal(in_op);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (word),
    .rd_en   (pop),
    .rd_data (out_instr),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    err_d = accept && !is_legal(in_op);
    cnt_d = cnt_q;
    if (pop) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_illegal  = err_q;
  assign issued_count = cnt_q;
  assign level        = fifo_level;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against a queue-based
// model of the encoder, its FIFO and its issued-word counter.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LVL_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             reset, in_valid, out_ready;
  logic [2:0]       in_op;
  logic [4:0]       in_rs, in_rt, in_rd;
  logic [15:0]      in_imm;
  logic             in_ready, out_valid, err_illegal;
  logic [31:0]      out_instr;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] issued_count;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rs        (in_rs),
    .in_rt        (in_rt),
    .in_rd        (in_rd),
    .in_imm       (in_imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .err_illegal  (err_illegal),
    .level        (level),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] q_m[$];
  int          cnt_m = 0;
  bit          err_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rs, input int rt,
                                      input int rd, input int imm);
    int opc;
    case (op)
      0: opc = 1;
      1: opc = 3;
      2: opc = 5;
      3: opc = 6;
      4: opc = 2;
      default: opc = 4;
    endcase
    if (op < 4) return 32'(opc * 67108864 + rs * 2097152 + rt * 65536 + rd * 2048);
    else        return 32'(opc * 67108864 + rs * 2097152 + rt * 65536 + imm);
  endfunction

  // One clock: check registered outputs, drive inputs, check in_ready, advance model.
  task automatic cycle(input bit rst, input bit v, input int op, input int rs,
                       input int rt, input int rd, input int imm, input bit rdy);
    bit exp_rdy, acc, pp;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(q_m.size() != 0));
    chk("out_instr", out_instr, (q_m.size() != 0) ? q_m[0] : 32'h0);
    chk("level", 32'(level), 32'(q_m.size()));
    chk("issued_count", 32'(issued_count), 32'(cnt_m));
    chk("err_illegal", 32'(err_illegal), 32'(err_m));
    reset     = rst;
    in_valid  = v;
    in_op     = 3'(op);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_imm    = 16'(imm);
    out_ready = rdy;
    #1;
    exp_rdy = !rst && (q_m.size() < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    pp  = !rst && (q_m.size() != 0) && rdy;
    @(posedge clk);
    if (rst) begin
      q_m.delete();
      cnt_m = 0;
      err_m = 1'b0;
    end else begin
      if (pp) begin
        $display("pop  %h count=%0d", q_m[0], (cnt_m + 1) % 16);
        void'(q_m.pop_front());
        cnt_m = (cnt_m + 1) % (1 << CNT_W);
      end
      if (acc && op < 6) begin
        q_m.push_back(enc(op, rs, rt, rd, imm));
        $display("push op=%0d word=%h", op, enc(op, rs, rt, rd, imm));
      end
      err_m = acc && (op >= 6);
      if (err_m) $display("illegal op=%0d accepted", op);
    end
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 1'b0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;

    cycle(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    cycle(1'b1, 1'b1, 0, 1, 1, 1, 0, 1'b1);

    // ADD rs=2 rt=3 rd=1
    cycle(1'b0, 1'b1, 0, 2, 3, 1, 16'h5555, 1'b1);
    #1 chk("add_word", out_instr, 32'h04430800);
    idle(1'b1);
    #1 chk("add_issued", 32'(issued_count), 32'd1);
    chk("add_level", 32'(level), 32'd0);

    // LW then SW held, then drained in order
    cycle(1'b0, 1'b1, 4, 4, 5, 7, 16'h0010, 1'b0);
    cycle(1'b0, 1'b1, 5, 4, 5, 7, 16'hFFFC, 1'b0);
    #1 chk("lwsw_level", 32'(level), 32'd2);
    chk("lw_word", out_instr, 32'h08850010);
    idle(1'b0);
    #1 chk("lw_hold", out_instr, 32'h08850010);
    idle(1'b1);
    #1 chk("sw_word", out_instr, 32'h1085FFFC);
    idle(1'b1);

    // illegal op
    cycle(1'b0, 1'b1, 7, 1, 2, 3, 0, 1'b1);
    #1 chk("illegal_pulse", 32'(err_illegal), 32'd1);
    idle(1'b1);
    #1 chk("illegal_gone", 32'(err_illegal), 32'd0);
    chk("illegal_level", 32'(level), 32'd0);

    // fill with OR rs=1 rt=2 rd=3
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 3, 1, 2, 3, 0, 1'b0);
    #1 chk("full_level", 32'(level), 32'd4);
    chk("or_word", out_instr, 32'h18221800);
    cycle(1'b0, 1'b1, 3, 1, 2, 3, 0, 1'b0);
    cycle(1'b0, 1'b1, 3, 1, 2, 3, 0, 1'b1);
    #1 chk("full_after_pop", 32'(level), 32'd3);
    cycle(1'b0, 1'b1, 3, 1, 2, 3, 0, 1'b0);
    #1 chk("fifth_accepted", 32'(level), 32'd4);
    idle(1'b1);

    // reset with level 3 and a pending request
    cycle(1'b1, 1'b1, 0, 2, 3, 1, 0, 1'b1);
    #1 chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(issued_count), 32'd0);

    // counter wrap with level held at 2 by simultaneous push/pop
    cycle(1'b0, 1'b1, 1, 9, 8, 7, 0, 1'b0);
    cycle(1'b0, 1'b1, 2, 6, 5, 4, 0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, i % 6, i, 31 - i, i + 3, i * 4099, 1'b1);
    #1 chk("wrap_count", 32'(issued_count), 32'd0);
    chk("pushpop_level", 32'(level), 32'd2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 65535)), $urandom_range(0, 2) != 0);
    end
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Producer end of the opcode interface: converts symbolic operation requests into 32-bit instruction words whose [31:26] opcode field the processor control decoder consumes.
- Sits between the test/program loader and instruction memory.
- Accepts requests on a valid/ready handshake, encodes them, buffers words in a FIFO, and emits them on a second valid/ready handshake.
- Rejects illegal operations and counts issued words.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, >=2.
- CNT_W, 16: width of the issued-word counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_op  in  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 LW, 5 SW; 6 and 7 are illegal
- in_rs  in  5  source register 1 / base register
- in_rt  in  5  source register 2 (R-type); destination for LW; data for SW
- in_rd  in  5  destination register (R-type only)
- in_imm  in  16  offset (LW/SW only)
- out_valid  out  1  instruction word available
- out_ready  in  1  consumer accepts the word
- out_instr  out  32  encoded instruction word
- err_illegal  out  1  one-cycle pulse when an illegal op is accepted
- level  out  $clog2(DEPTH+1)  current FIFO occupancy
- issued_count  out  CNT_W  number of words popped; wraps modulo 2^CNT_W

Behaviour:
- Reset (synchronous, active-high):
  - level=0, out_valid=0, out_instr=0, err_illegal=0, issued_count=0, pointers cleared.
  - in_ready=0 during the reset cycle; any handshake in that cycle is ignored.
  - Reset mid-operation discards all buffered words and produces no output pulse.
- Opcode map: ADD=6'd1, SUB=6'd3, AND=6'd5, OR=6'd6, LW=6'd2, SW=6'd4.
- R-type (ADD/SUB/AND/OR) word: {opcode, rs, rt, rd, 11'b0}; in_imm ignored.
- I-type (LW/SW) word: {opcode, rs, rt, imm}; in_rd ignored.
- Input handshake:
  - in_ready = !reset && (level < DEPTH), derived combinationally from registered state.
  - Transfer occurs when in_valid && in_ready.
  - Legal op: encoded word written at the tail; out_valid rises no earlier than the next cycle (latency 1, no combinational bypass).
  - Illegal op (6, 7): still handshaked, so the source never stalls; nothing is written; err_illegal=1 in the following cycle only; level unchanged.
- Output handshake:
  - First-word-fall-through: out_valid = (level != 0); out_instr = head word, forced to 0 when empty.
  - Pop when out_valid && out_ready; issued_count increments by 1 on each pop.
  - out_instr is held stable while out_valid && !out_ready.
- Simultaneous push and pop with 0 < level < DEPTH: level unchanged, both take effect.
- Full (level=DEPTH): in_ready=0; a pop in that cycle frees a slot, but in_ready reflects that only from the next cycle.
- Empty: a pop is impossible; out_ready is ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are tracked via level.
- issued_count wraps from 2^CNT_W-1 to 0 without a flag.

Decomposition:
- Package proc_isa_pkg holds:
  - op enum (OP_ADD..OP_SW).
  - 6-bit opcode constants OPC_ADD=1, OPC_LW=2, OPC_SUB=3, OPC_SW=4, OPC_AND=5, OPC_OR=6.
  - Field bit positions (OPC 31:26, RS 25:21, RT 20:16, RD 15:11, IMM 15:0).
  - is_rtype / is_legal helper functions.
- The controller decoder will share this package.
- One sub-module: sync_fifo (DEPTH, WIDTH=32, FWFT, level output).
- Encode logic and counters stay in instr_encoder.

Test Plan:
- Reset then ADD rs=2 rt=3 rd=1, out_ready=1 -> next cycle out_valid=1, out_instr=0x04430800; after the pop issued_count=1 and level=0.
- LW rs=4 rt=5 imm=0x0010, then SW rs=4 rt=5 imm=0xFFFC, out_ready=0 -> level=2, head=0x08850010; raise out_ready -> 0x08850010 then 0x1085FFFC, in order.
- in_op=7 with in_valid=1 -> in_ready=1, err_illegal high for exactly one cycle, level stays 0, out_valid stays 0.
- Push 5 ORs (rs=1 rt=2 rd=3 -> 0x18221800) with out_ready=0 -> in_ready=0 after the 4th push, level=4, 5th request held; one pop -> 5th accepted the following cycle.
- Reset asserted with level=3 and in_valid=1 -> next cycle level=0, out_valid=0, issued_count=0, no err_illegal pulse, the reset-cycle request not enqueued.
- CNT_W=4: 16 pops -> issued_count wraps to 0; a push and pop together at level=2 -> level stays 2.
